// File: rtl/wb_mem_master_pkg.sv
// Shared definitions for the Wishbone memory master slice.
//   state_e          FSM encoding (IDLE/REQ/WAIT/RESP, 2 bits)
//   TIMEOUT_DEFAULT  default bus timeout in cycles (0 disables the timeout)
//   WB_SEL_ALL       all-ones byte-select source, sliced to the bus width
//   cnt_width()      bit width of a counter that must reach TIMEOUT
package wb_mem_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int TIMEOUT_DEFAULT = 255;

    // Wide enough for any data bus up to 1024 bits; users slice the low bits.
    localparam logic [127:0] WB_SEL_ALL = {128{1'b1}};

    // A zero-bit counter is not legal, so a disabled timeout still gets one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_mem_master_timeout_cnt.sv
// Bus timeout counter.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clr_i         restart the count from zero (new bus cycle)
//   en_i          count one cycle of waiting for the slave
//   expire_o      high while the count sits on the last allowed wait cycle
// The count saturates at TIMEOUT; with TIMEOUT = 0 expire_o never rises.
module wb_timeout_cnt
    import wb_mem_master_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int               CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic             CNT_ON   = (TIMEOUT != 0);

    logic [CNT_W-1:0] cnt_r;

    // Saturating wait-cycle counter, cleared at the start of every bus cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (clr_i) begin
            cnt_r <= '0;
        end else if (en_i && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // The count reads k-1 on the k-th wait cycle, so TIMEOUT-1 marks the last one.
    assign expire_o = CNT_ON && (cnt_r == CNT_LAST);

endmodule

// File: rtl/wb_mem_master.sv
// Wishbone B4 pipelined master: drains the request FIFO, one bus cycle per
// request, one transaction outstanding, one in-order response per cycle.
//   req_*   request FIFO side (req_pop_o is a same-cycle pulse from IDLE)
//   resp_*  response FIFO side (held in RESP until resp_accept_i)
//   wb_*    Wishbone bus; cyc/stb/resp_valid are flops cleared by rst_i
// A slave that neither acks nor errors within TIMEOUT wait cycles produces an
// error response. ack/err outside REQ/WAIT are ignored.
module wb_mem_master
    import wb_mem_master_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_data_i,
    input  logic [DATA_W/8-1:0] req_wr_i,
    output logic                req_pop_o,
    output logic                resp_valid_o,
    output logic [DATA_W-1:0]   resp_data_o,
    output logic                resp_err_o,
    input  logic                resp_accept_i,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    input  logic                wb_stall_i
);

    localparam int                SEL_W    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ADR_MASK = ~ADDR_W'(SEL_W - 1);
    localparam logic [SEL_W-1:0]  SEL_ALL  = WB_SEL_ALL[SEL_W-1:0];

    state_e              state_r;
    state_e              state_s;
    logic                pop_s;
    logic                done_s;
    logic                done_err_s;
    logic [DATA_W-1:0]   done_data_s;
    logic                expire_s;

    logic                cyc_r;
    logic                stb_r;
    logic                resp_valid_r;
    logic                we_r;
    logic [SEL_W-1:0]    sel_r;
    logic [ADDR_W-1:0]   adr_r;
    logic [DATA_W-1:0]   dat_r;
    logic [DATA_W-1:0]   resp_data_r;
    logic                resp_err_r;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (pop_s),
        .en_i     (state_r == ST_WAIT),
        .expire_o (expire_s)
    );

    // Next state, request pop and response capture; err outranks ack, ack outranks timeout.
    always_comb begin
        state_s     = state_r;
        pop_s       = 1'b0;
        done_s      = 1'b0;
        done_err_s  = 1'b0;
        done_data_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i) begin
                    pop_s   = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A stalled strobe is not accepted, so any ack/err then is not ours.
                if (wb_stall_i) begin
                    state_s = ST_REQ;
                end else if (wb_err_i) begin
                    done_s     = 1'b1;
                    done_err_s = 1'b1;
                    state_s    = ST_RESP;
                end else if (wb_ack_i) begin
                    done_s      = 1'b1;
                    done_data_s = we_r ? '0 : wb_dat_i;
                    state_s     = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wb_err_i) begin
                    done_s     = 1'b1;
                    done_err_s = 1'b1;
                    state_s    = ST_RESP;
                end else if (wb_ack_i) begin
                    done_s      = 1'b1;
                    done_data_s = we_r ? '0 : wb_dat_i;
                    state_s     = ST_RESP;
                end else if (expire_s) begin
                    done_s     = 1'b1;
                    done_err_s = 1'b1;
                    state_s    = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_accept_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register; handshake flags are decoded from the next state so they flop with it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cyc_r        <= (state_s == ST_REQ) || (state_s == ST_WAIT);
            stb_r        <= (state_s == ST_REQ);
            resp_valid_r <= (state_s == ST_RESP);
        end
    end

    // Request holding registers, loaded on the pop so the FIFO head may move on.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            adr_r <= '0;
            dat_r <= '0;
            sel_r <= '0;
            we_r  <= 1'b0;
        end else if (pop_s) begin
            adr_r <= req_addr_i & ADR_MASK;
            dat_r <= req_data_i;
            sel_r <= (|req_wr_i) ? req_wr_i : SEL_ALL;
            we_r  <= |req_wr_i;
        end
    end

    // Response holding registers, stable for the whole RESP state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_data_r <= '0;
            resp_err_r  <= 1'b0;
        end else if (done_s) begin
            resp_data_r <= done_data_s;
            resp_err_r  <= done_err_s;
        end
    end

    assign req_pop_o    = pop_s;
    assign resp_valid_o = resp_valid_r;
    assign resp_data_o  = resp_data_r;
    assign resp_err_o   = resp_err_r;
    assign wb_cyc_o     = cyc_r;
    assign wb_stb_o     = stb_r;
    assign wb_we_o      = we_r;
    assign wb_sel_o     = sel_r;
    assign wb_adr_o     = adr_r;
    assign wb_dat_o     = dat_r;

endmodule

// File: tb/tb_wb_mem_master.sv
// Self-checking bench for wb_mem_master (TIMEOUT = 8): directed table, random
// transactions against a transaction-level model, and a mid-cycle reset.
module tb_wb_mem_master;

    localparam int TMO = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wr;
        logic [31:0] rdata;
        int          stall_n;   // stalled REQ cycles before acceptance
        int          resp_at;   // 0: with accepting edge, k: k-th wait cycle, -1: never
        int          kind;      // 0 ack, 1 err, 2 ack+err
        int          acc_dly;   // cycles resp_accept stays low
        logic [31:0] exp_adr;
        logic [3:0]  exp_sel;
        logic        exp_we;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_pop_o, resp_valid_o, resp_err_o, resp_accept_i;
    logic [31:0] req_addr_i, req_data_i, resp_data_o, wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  req_wr_i, wb_sel_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i, wb_stall_i;

    int checks = 0;
    int errors = 0;
    vec_t tbl[9];

    wb_mem_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_wr_i(req_wr_i), .req_pop_o(req_pop_o),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
        .resp_accept_i(resp_accept_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level expectation: word-aligned address, byte selects,
    // and a response that is an error when the slave errs or never answers in time.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   late;
        r = v;
        late = (v.resp_at < 0) || (v.resp_at > TMO);
        r.exp_we   = (v.wr != 4'd0);
        r.exp_sel  = r.exp_we ? v.wr : 4'hF;
        r.exp_adr  = v.addr - (v.addr % 32'd4);
        r.exp_err  = late || (v.kind != 0);
        r.exp_data = (r.exp_err || r.exp_we) ? 32'd0 : v.rdata;
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        bit tmo;
        int n_wait;
        tmo = (v.resp_at < 0) || (v.resp_at > TMO);
        n_wait = (v.resp_at == 0) ? 0 : (tmo ? TMO : v.resp_at);
        // IDLE: request presented, popped the same cycle
        @(negedge clk_i);
        req_valid_i = 1'b1; req_addr_i = v.addr; req_data_i = v.wdata; req_wr_i = v.wr;
        resp_accept_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;
        #1;
        chk("pop", req_pop_o, 32'd1);
        chk("idle_cyc", wb_cyc_o, 32'd0);
        chk("idle_rvalid", resp_valid_o, 32'd0);
        // REQ: strobe held through stalls, request FIFO head scrambled to prove latching
        for (int s = 0; s <= v.stall_n; s++) begin
            @(negedge clk_i);
            req_addr_i = $urandom; req_data_i = $urandom; req_wr_i = 4'($urandom);
            wb_stall_i = (s < v.stall_n);
            wb_ack_i = (s == v.stall_n) && (v.resp_at == 0) && (v.kind != 1);
            wb_err_i = (s == v.stall_n) && (v.resp_at == 0) && (v.kind != 0);
            wb_dat_i = v.rdata;
            #1;
            chk("req_cyc", wb_cyc_o, 32'd1);
            chk("req_stb", wb_stb_o, 32'd1);
            chk("req_adr", wb_adr_o, v.exp_adr);
            chk("req_sel", wb_sel_o, v.exp_sel);
            chk("req_we", wb_we_o, v.exp_we);
            chk("req_nopop", req_pop_o, 32'd0);
            if (v.exp_we) chk("req_dat", wb_dat_o, v.wdata);
        end
        // WAIT: cycle open, strobe dropped
        for (int w = 1; w <= n_wait; w++) begin
            @(negedge clk_i);
            wb_stall_i = 1'b0;
            wb_ack_i = (w == v.resp_at) && (v.kind != 1);
            wb_err_i = (w == v.resp_at) && (v.kind != 0);
            #1;
            chk("wait_cyc", wb_cyc_o, 32'd1);
            chk("wait_stb", wb_stb_o, 32'd0);
            chk("wait_nopop", req_pop_o, 32'd0);
        end
        // RESP: held until accepted; a late ack after timeout must change nothing
        for (int a = 0; a <= v.acc_dly; a++) begin
            @(negedge clk_i);
            wb_ack_i = tmo && (a == 0); wb_err_i = 1'b0; wb_dat_i = $urandom;
            resp_accept_i = (a == v.acc_dly);
            #1;
            chk("resp_valid", resp_valid_o, 32'd1);
            chk("resp_data", resp_data_o, v.exp_data);
            chk("resp_err", resp_err_o, v.exp_err);
            chk("resp_cyc", wb_cyc_o, 32'd0);
            chk("resp_stb", wb_stb_o, 32'd0);
            chk("resp_nopop", req_pop_o, 32'd0);
        end
    endtask

    // Drop the request line; spurious ack/err in IDLE must not start anything.
    task automatic go_idle();
        @(negedge clk_i);
        req_valid_i = 1'b0; resp_accept_i = 1'b0; wb_ack_i = 1'b1; wb_err_i = 1'b1;
        #1;
        chk("idle_pop", req_pop_o, 32'd0);
        @(negedge clk_i);
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        #1;
        chk("idle_spur_cyc", wb_cyc_o, 32'd0);
        chk("idle_spur_rv", resp_valid_o, 32'd0);
    endtask

    initial begin
        vec_t v;
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_addr_i = 32'd0; req_data_i = 32'd0; req_wr_i = 4'd0;
        resp_accept_i = 1'b0; wb_dat_i = 32'd0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;

        //            addr          wdata         wr       rdata         stl ra  k  acc  adr           sel      we    data          err
        tbl[0] = '{32'h0000_0100, 32'h0,        4'b0000, 32'hDEADBEEF, 0,  1, 0, 0, 32'h0000_0100, 4'hF,    1'b0, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{32'h0000_1003, 32'h11223344, 4'b0110, 32'h55555555, 3,  1, 0, 0, 32'h0000_1000, 4'b0110, 1'b1, 32'h0,        1'b0};
        tbl[2] = '{32'h0000_2000, 32'h0,        4'b0000, 32'h77777777, 0, -1, 0, 0, 32'h0000_2000, 4'hF,    1'b0, 32'h0,        1'b1};
        tbl[3] = '{32'h0000_2104, 32'h0,        4'b0000, 32'hCAFEF00D, 0,  1, 2, 0, 32'h0000_2104, 4'hF,    1'b0, 32'h0,        1'b1};
        tbl[4] = '{32'h0000_3004, 32'h0,        4'b0000, 32'h12345678, 0,  0, 0, 5, 32'h0000_3004, 4'hF,    1'b0, 32'h12345678, 1'b0};
        tbl[5] = '{32'h0000_3008, 32'hA5A5A5A5, 4'b1111, 32'h99999999, 0,  2, 0, 0, 32'h0000_3008, 4'hF,    1'b1, 32'h0,        1'b0};
        tbl[6] = '{32'h0000_4002, 32'h0,        4'b0000, 32'h13572468, 2,  0, 1, 1, 32'h0000_4000, 4'hF,    1'b0, 32'h0,        1'b1};
        tbl[7] = '{32'h0000_0047, 32'h0,        4'b0000, 32'h0BADF00D, 0,  8, 0, 0, 32'h0000_0044, 4'hF,    1'b0, 32'h0BADF00D, 1'b0};
        tbl[8] = '{32'h0000_0050, 32'hFFFF0000, 4'b1000, 32'h24682468, 1,  9, 0, 2, 32'h0000_0050, 4'b1000, 1'b1, 32'h0,        1'b1};

        // Reset state: every output low
        #1;
        chk("rst_pop", req_pop_o, 32'd0);
        chk("rst_rvalid", resp_valid_o, 32'd0);
        chk("rst_rdata", resp_data_o, 32'd0);
        chk("rst_rerr", resp_err_o, 32'd0);
        chk("rst_cyc", wb_cyc_o, 32'd0);
        chk("rst_stb", wb_stb_o, 32'd0);
        chk("rst_we", wb_we_o, 32'd0);
        chk("rst_sel", wb_sel_o, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Directed table, back to back (entries 4 -> 5 exercise held accept)
        for (int i = 0; i < 9; i++) run_txn(tbl[i]);
        go_idle();

        // Random transactions against the model
        for (int i = 0; i < 60; i++) begin
            v.addr    = $urandom;
            v.wdata   = $urandom;
            v.wr      = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            v.rdata   = $urandom;
            v.stall_n = $urandom_range(0, 3);
            v.resp_at = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 10);
            v.kind    = $urandom_range(0, 2);
            v.acc_dly = $urandom_range(0, 3);
            v = model(v);
            run_txn(v);
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();

        // Reset while in WAIT: bus and response drop at once, then a clean request
        @(negedge clk_i);
        req_valid_i = 1'b1; req_addr_i = 32'h0000_5000; req_wr_i = 4'd0;
        wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        #1;
        chk("rw_pop", req_pop_o, 32'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        #1;
        chk("rw_stb", wb_stb_o, 32'd1);
        @(negedge clk_i);
        #1;
        chk("rw_wait_cyc", wb_cyc_o, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("rw_cyc", wb_cyc_o, 32'd0);
        chk("rw_stb0", wb_stb_o, 32'd0);
        chk("rw_rvalid", resp_valid_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rw_after_cyc", wb_cyc_o, 32'd0);
        chk("rw_after_pop", req_pop_o, 32'd0);
        run_txn(tbl[0]);
        go_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
